// File: rtl/target_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : target_scheduler_pkg
// Brief   : Shared types, sizes and helpers for the target scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package target_scheduler_pkg;

    // Target life-cycle codes reported by each slot
    typedef enum logic [1:0] {
        ST_INITIAL = 2'd0,
        ST_FLYING  = 2'd1,
        ST_DYING   = 2'd2
    } tgt_state_e;

    localparam int NUM_LANES = 8;
    localparam int NUM_SLOTS = 4;
    localparam int LANE_W    = $clog2(NUM_LANES);

    // Galois feedback mask for x^8 + x^6 + x^5 + x^4 + 1 (right-shifting form)
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Pending age at which an unclaimed spawn reservation expires
    localparam logic [1:0] PEND_LAST = 2'd2;

    // Isolates the lowest set bit; shared by spawn and shot arbitration
    function automatic logic [NUM_SLOTS-1:0] lowest_onehot(input logic [NUM_SLOTS-1:0] req);
        return req & (~req + NUM_SLOTS'(1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/target_scheduler_lfsr8.sv
`default_nettype none
// ============================================================================
// Module  : lfsr8
// Brief   : Free-running 8-bit Galois LFSR; a zero seed is forced to 8'h01
//           so the register can never lock up in the all-zero state.
// Revision: 1.0 - initial release
// ============================================================================
module lfsr8
    import target_scheduler_pkg::*;
(
    input  logic       clk_100Hz,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic [7:0] w_seed;

    assign w_seed = (seed == 8'h00) ? 8'h01 : seed;

    // Shift right, folding the tap mask in whenever a one falls out
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[7:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ LFSR_TAPS;
        end
    end

    // State register, reloaded with the seed on reset
    always_ff @(posedge clk_100Hz) begin
        if (rst) begin
            lfsr_q <= w_seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/target_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : target_scheduler
// Brief   : Spawns targets into free slots on random, non-colliding lanes at a
//           fixed interval, and arbitrates a single bullet among hit slots.
// Revision: 1.0 - initial release
// ============================================================================
module target_scheduler
    import target_scheduler_pkg::*;
#(
    parameter int         SPAWN_INTERVAL = 50,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic        clk_100Hz,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  slot_state,
    input  logic [3:0]  hit_req,
    output logic [3:0]  start,
    output logic [11:0] din,
    output logic [3:0]  shot,
    output logic [7:0]  score
);

    localparam logic [9:0] TERMINAL = 10'(SPAWN_INTERVAL - 1);

    logic [9:0]  cnt_q,   cnt_d;
    logic [3:0]  start_q;
    logic [3:0]  shot_q;
    logic [11:0] din_q,   din_d;
    logic [7:0]  score_q, score_d;
    logic [3:0]  pend_q,  pend_d;
    logic [7:0]  age_q,   age_d;
    logic [3:0]  blk_q,   blk_d;

    logic [7:0]        w_lfsr;
    logic [LANE_W-1:0] w_lane;
    logic [3:0]        w_flying;
    logic [3:0]        w_idle;
    logic [3:0]        w_conflict;
    logic [3:0]        w_spawn_gnt;
    logic [3:0]        w_shot_gnt;
    logic              w_attempt;
    logic              w_accept;

    lfsr8 u_lfsr (
        .clk_100Hz (clk_100Hz),
        .rst       (rst),
        .seed      (LFSR_SEED),
        .q         (w_lfsr)
    );

    assign w_lane = w_lfsr[LANE_W-1:0];

    // Per-slot status: flying, free for a spawn, or already owning the candidate lane
    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign w_flying[gi]   = (slot_state[2*gi +: 2] == ST_FLYING);
            assign w_idle[gi]     = (slot_state[2*gi +: 2] == ST_INITIAL) && !pend_q[gi];
            assign w_conflict[gi] = (w_flying[gi] || pend_q[gi])
                                 && (din_q[LANE_W*gi +: LANE_W] == w_lane);
        end
    endgenerate

    assign w_attempt   = enable && (cnt_q == TERMINAL);
    assign w_accept    = w_attempt && (|w_idle) && !(|w_conflict);
    assign w_spawn_gnt = w_accept ? lowest_onehot(w_idle) : 4'b0000;
    assign w_shot_gnt  = lowest_onehot(hit_req & w_flying & ~blk_q & {4{enable}});

    // Interval counter: counts while enabled, parks at terminal until a spawn is accepted
    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            if (cnt_q != TERMINAL) begin
                cnt_d = cnt_q + 10'd1;
            end else if (w_accept) begin
                cnt_d = '0;
            end
        end
    end

    // Kill counter, saturating at full scale
    always_comb begin
        score_d = score_q;
        if ((|w_shot_gnt) && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
        end
    end

    // Per-slot lane, spawn reservation timer and shot lockout
    always_comb begin
        din_d  = din_q;
        pend_d = pend_q;
        age_d  = age_q;
        blk_d  = blk_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (pend_q[i]) begin
                if (w_flying[i] || (age_q[2*i +: 2] == PEND_LAST)) begin
                    pend_d[i]      = 1'b0;
                    age_d[2*i +: 2] = 2'd0;
                end else begin
                    age_d[2*i +: 2] = age_q[2*i +: 2] + 2'd1;
                end
            end
            if (w_spawn_gnt[i]) begin
                pend_d[i]                 = 1'b1;
                age_d[2*i +: 2]           = 2'd0;
                din_d[LANE_W*i +: LANE_W] = w_lane;
            end
            blk_d[i] = w_flying[i] && (blk_q[i] || w_shot_gnt[i]);
        end
    end

    // State and output registers
    always_ff @(posedge clk_100Hz) begin
        if (rst) begin
            cnt_q   <= '0;
            start_q <= '0;
            shot_q  <= '0;
            din_q   <= '0;
            score_q <= '0;
            pend_q  <= '0;
            age_q   <= '0;
            blk_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            start_q <= w_spawn_gnt;
            shot_q  <= w_shot_gnt;
            din_q   <= din_d;
            score_q <= score_d;
            pend_q  <= pend_d;
            age_q   <= age_d;
            blk_q   <= blk_d;
        end
    end

    assign start = start_q;
    assign shot  = shot_q;
    assign din   = din_q;
    assign score = score_q;

endmodule
`default_nettype wire

// File: tb/tb_target_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_target_scheduler
// Brief   : Scoreboard bench for target_scheduler with a cycle-level
//           behavioural model, directed scenarios and a randomized phase.
// Revision: 1.0 - initial release
// ============================================================================
module tb_target_scheduler;

    localparam int         SPAWN_INTERVAL = 4;
    localparam logic [7:0] SEED           = 8'hA5;

    logic        clk_100Hz = 1'b0;
    logic        rst       = 1'b1;
    logic        enable    = 1'b1;
    logic [7:0]  slot_state = 8'h00;
    logic [3:0]  hit_req   = 4'h0;
    logic [3:0]  start;
    logic [11:0] din;
    logic [3:0]  shot;
    logic [7:0]  score;

    int n_checks = 0;
    int n_errors = 0;

    target_scheduler #(
        .SPAWN_INTERVAL (SPAWN_INTERVAL),
        .LFSR_SEED      (SEED)
    ) dut (
        .clk_100Hz  (clk_100Hz),
        .rst        (rst),
        .enable     (enable),
        .slot_state (slot_state),
        .hit_req    (hit_req),
        .start      (start),
        .din        (din),
        .shot       (shot),
        .score      (score)
    );

    always #5 clk_100Hz = ~clk_100Hz;

    typedef struct {
        logic [3:0]  start;
        logic [11:0] din;
        logic [3:0]  shot;
        logic [7:0]  score;
    } exp_t;

    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    // ---------------- behavioural reference model ----------------
    logic [7:0] m_lfsr;
    int         m_cnt;
    int         m_pend  [4];   // cycles of reservation left, 0 = none
    logic [2:0] m_lane  [4];
    bit         m_blk   [4];
    int         m_score;

    always @(posedge clk_100Hz) begin
        exp_t       e;
        int         sp;
        int         sh;
        logic [2:0] lane;
        bit         busy;
        logic [1:0] st [4];
        for (int i = 0; i < 4; i++) st[i] = slot_state[2*i +: 2];
        sp   = -1;
        sh   = -1;
        lane = 3'd0;
        if (rst) begin
            m_lfsr  = SEED;
            m_cnt   = 0;
            m_score = 0;
            for (int i = 0; i < 4; i++) begin
                m_pend[i] = 0;
                m_lane[i] = 3'd0;
                m_blk[i]  = 1'b0;
            end
        end else begin
            if (enable)
                for (int i = 0; i < 4; i++)
                    if (sh < 0 && hit_req[i] && st[i] == 2'd1 && !m_blk[i]) sh = i;
            if (enable && m_cnt == SPAWN_INTERVAL - 1) begin
                lane = m_lfsr[2:0];
                busy = 1'b0;
                for (int i = 0; i < 4; i++)
                    if ((st[i] == 2'd1 || m_pend[i] > 0) && m_lane[i] == lane) busy = 1'b1;
                if (!busy)
                    for (int i = 0; i < 4; i++)
                        if (sp < 0 && st[i] == 2'd0 && m_pend[i] == 0) sp = i;
            end
            for (int i = 0; i < 4; i++)
                if (m_pend[i] > 0) m_pend[i] = (st[i] == 2'd1) ? 0 : m_pend[i] - 1;
            if (sp >= 0) begin
                m_pend[sp] = 3;
                m_lane[sp] = lane;
                m_cnt      = 0;
            end else if (enable && m_cnt < SPAWN_INTERVAL - 1) begin
                m_cnt++;
            end
            for (int i = 0; i < 4; i++) m_blk[i] = (st[i] == 2'd1) && (m_blk[i] || sh == i);
            if (sh >= 0 && m_score < 255) m_score++;
            m_lfsr = lfsr_next(m_lfsr);
        end
        e.start = (sp >= 0) ? 4'(1 << sp) : 4'h0;
        e.shot  = (sh >= 0) ? 4'(1 << sh) : 4'h0;
        e.din   = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
        e.score = 8'(m_score);
        sbq.push_back(e);
    end

    // ---------------- monitor ----------------
    always @(negedge clk_100Hz) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("sb_start", start, e.start);
            check("sb_shot",  shot,  e.shot);
            check("sb_score", score, e.score);
            if (start != 4'h0) check("sb_din", din, e.din);
            check("start_onehot", ($countones(start) <= 1), 1);
        end
    end

    // ---------------- slot environment ----------------
    bit env_on   = 1'b0;
    bit hit_en   = 1'b0;
    int env_life = 15;
    int env_ph [4];
    int env_t  [4];

    task automatic tick();
        @(negedge clk_100Hz);
        if (env_on) begin
            for (int i = 0; i < 4; i++) begin
                case (env_ph[i])
                    0: if (start[i]) begin env_ph[i] = 1; env_t[i] = $urandom_range(0, 4); end
                    1: if (env_t[i] == 0) begin env_ph[i] = 2; env_t[i] = $urandom_range(2, env_life); end
                       else env_t[i]--;
                    2: if (env_t[i] == 0) begin env_ph[i] = 3; env_t[i] = 1; end
                       else env_t[i]--;
                    default: if (env_t[i] == 0) env_ph[i] = 0; else env_t[i]--;
                endcase
                slot_state[2*i +: 2] = (env_ph[i] == 2) ? 2'd1 : (env_ph[i] == 3) ? 2'd2 : 2'd0;
            end
            hit_req = hit_en ? 4'($urandom_range(0, 15)) : 4'h0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] v;
        bit         seen;
        int         cnt;
        int         s0;
        for (int i = 0; i < 4; i++) begin env_ph[i] = 0; env_t[i] = 0; end

        // First spawn timing after a one-cycle reset
        env_on = 1'b1;
        tick();
        check("rst_start", start, 4'h0);
        check("rst_score", score, 8'h00);
        check("rst_din",   din,   12'h000);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("pre_spawn", start, 4'h0);
        end
        tick();
        check("first_start", start, 4'b0001);
        v = SEED;
        for (int k = 0; k < 3; k++) v = lfsr_next(v);
        check("first_din", din[2:0], v[2:0]);

        // Fill slots with long-lived targets; slot 3 must eventually get a free lane
        env_life = 300;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            tick();
            if (start[3]) seen = 1'b1;
        end
        check("slot3_spawn", seen, 1);

        // Single-bullet arbitration
        env_on = 1'b0;
        slot_state = 8'h00;
        hit_req = 4'h0;
        tick();
        tick();
        slot_state = 8'b00_01_01_00;
        hit_req = 4'b0110;
        tick();
        check("shot_lowest", shot, 4'b0010);
        hit_req = 4'h0;
        tick();

        // Held hit request yields exactly one kill
        s0 = score;
        cnt = 0;
        hit_req = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            slot_state = (k < 5) ? 8'h01 : 8'h02;
            tick();
            if (shot[0]) cnt++;
        end
        hit_req = 4'h0;
        check("one_shot", cnt, 1);
        check("kill_score", score - s0, 1);

        // Drive the score into saturation
        hit_req = 4'b0001;
        for (int k = 0; k < 300; k++) begin
            slot_state = 8'h01;
            tick();
            slot_state = 8'h02;
            tick();
        end
        check("score_sat", score, 8'hFF);
        slot_state = 8'h01;
        tick();
        check("sat_shot",  shot,  4'b0001);
        check("sat_score", score, 8'hFF);
        hit_req = 4'h0;
        slot_state = 8'h00;

        // Reset landing on the spawn cycle, then a long disabled stretch
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rstwin_start", start, 4'h0);
        check("rstwin_score", score, 8'h00);
        check("rstwin_din",   din,   12'h000);
        rst = 1'b0;
        enable = 1'b0;
        slot_state = 8'b00_00_01_00;
        hit_req = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            tick();
            check("dis_start", start, 4'h0);
            check("dis_shot",  shot,  4'h0);
        end
        enable = 1'b1;
        slot_state = 8'h00;
        hit_req = 4'h0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("frozen_cnt", start, 4'h0);
        end
        tick();
        check("resume_start", start, 4'b0001);

        // Randomized traffic against the model
        for (int i = 0; i < 4; i++) begin env_ph[i] = 0; env_t[i] = 0; end
        env_on = 1'b1;
        hit_en = 1'b1;
        env_life = 15;
        for (int k = 0; k < 3000; k++) begin
            tick();
            enable = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 299) == 0);
        end
        rst = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/target_scheduler.md
TARGET_SCHEDULER -- requirements
Module: target_scheduler

Interface
REQ-001 The block SHALL have parameter SPAWN_INTERVAL, default 50, meaning clk_100Hz ticks between spawn attempts; legal range 4..1023.
REQ-002 The block SHALL have parameter LFSR_SEED, default 8'hA5, meaning the LFSR reset value; a value of 0 SHALL be replaced by 8'h01.
REQ-003 clk_100Hz  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  game running; when low, no spawns and no shots are issued.
REQ-006 slot_state  input  8  four 2-bit target states, slot i at [2i+1:2i]; 0=INITIAL, 1=FLYING, 2=DYING.
REQ-007 hit_req  input  4  per-slot bullet/target overlap from collision logic.
REQ-008 start  output  4  per-slot one-cycle spawn pulse, registered.
REQ-009 din  output  12  per-slot 3-bit lane index, slot i at [3i+2:3i], registered.
REQ-010 shot  output  4  per-slot one-cycle kill pulse, registered.
REQ-011 score  output  8  kill count, registered.

Function
REQ-012 An 8-bit Galois LFSR (x^8+x^6+x^5+x^4+1) SHALL advance every cycle regardless of enable, and SHALL never reach 0.
REQ-013 The spawn counter SHALL increment each cycle while enable=1, hold while enable=0, and saturate at SPAWN_INTERVAL-1 (terminal).
REQ-014 At terminal count, the block SHALL attempt a spawn with candidate lane = lfsr[2:0].
REQ-015 The spawn SHALL be rejected if no slot is idle: slot_state=0 and not marked pending.
REQ-016 The spawn SHALL also be rejected if the candidate lane equals the din lane of any slot in FLYING or pending.
REQ-017 On rejection, the counter SHALL hold at terminal and the spawn SHALL be retried next cycle with the new LFSR value.
REQ-018 On acceptance, the lowest-index idle slot i SHALL be selected.
REQ-019 On acceptance, din[i] SHALL be loaded with the lane in the same registered update that sets start[i]=1.
REQ-020 On acceptance, the counter SHALL be cleared to 0 and slot i SHALL be marked pending.
REQ-021 start SHALL be one-hot or zero every cycle, and SHALL be high for exactly one cycle per spawn.
REQ-022 din[i] SHALL hold its value until the next spawn into slot i.
REQ-023 Pending[i] SHALL clear when slot_state[i] reads FLYING, or after 3 cycles, whichever is first.
REQ-024 A slot SHALL be shot-eligible when hit_req[i]=1, slot_state[i]=FLYING and enable=1.
REQ-025 Among shot-eligible slots, only the lowest-index slot SHALL receive shot[i]=1, on the next cycle; the others SHALL be dropped (single bullet).
REQ-026 After shot[i], slot i SHALL be blocked from further shots until slot_state[i] leaves FLYING.
REQ-027 score SHALL increment by 1 in the cycle a shot pulse is registered, and SHALL saturate at 255.
REQ-028 When a spawn and a shot occur in the same cycle, both SHALL be issued, including when they target the same slot index in different states.
REQ-029 When enable falls mid-operation, any already-registered pulse SHALL complete and nothing new SHALL be issued; pending timers SHALL continue to run.

Reset
REQ-030 While rst=1, start, shot, din, score, the spawn counter, the pending and blocked flags SHALL be 0, and the LFSR SHALL equal its seed, on the next edge.
REQ-031 Reset SHALL take priority over every simultaneous event.
REQ-032 The first spawn attempt SHALL occur SPAWN_INTERVAL-1 enabled cycles after rst deasserts.

Structure
REQ-033 The shared package SHALL contain the target state codes (INITIAL/FLYING/DYING), the lane count 8, the slot count 4, and the LFSR tap constant.
REQ-034 The LFSR SHALL be a separate sub-module named lfsr8 with ports clk_100Hz, rst, seed, and q.
REQ-035 The slot-select priority encoder SHALL be a function in the shared package, reused by spawn and shot arbitration.

Verification
REQ-036 Scenario: rst 1 cycle, enable=1, all slots INITIAL, SPAWN_INTERVAL=4 -> start=4'b0001 on the 4th cycle after reset, with din[2:0]=LFSR[2:0] in the same cycle.
REQ-037 Scenario: slots 0-2 FLYING on lanes 0, 1, 2, slot 3 idle, LFSR lane hits 1 -> no start that cycle; retry until lane is not in {0,1,2}, then start=4'b1000.
REQ-038 Scenario: hit_req=4'b0110 with slots 1 and 2 FLYING -> shot=4'b0010 next cycle, score 0->1, slot 2 not shot that cycle.
REQ-039 Scenario: hit_req[0] held high for 10 cycles while slot 0 FLYING then DYING -> exactly one shot pulse; score increments by 1.
REQ-040 Scenario: score at 255 and a new kill -> shot pulse issued, score stays 255.
REQ-041 Scenario: rst asserted in the cycle start would fire -> start=0, counter=0, LFSR=seed; enable low for 20 cycles -> no start or shot, counter frozen.
